// File: rtl/axis_chan_packetizer.sv
// rtl/axis_chan_packetizer.sv - frames a channel-tagged AXI stream into headered, length-bounded packets
module axis_chan_packetizer #(
  parameter int NUM_CHAN   = 6,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BEATS  = 64,
  parameter int SEQ_WIDTH  = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_rstn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [NUM_CHAN-1:0]   s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  chan_err
);

  typedef enum logic {IDLE, BODY} state_t;

  localparam logic [15:0] LAST_IDX = 16'(MAX_BEATS - 1);

  state_t                state;
  logic [NUM_CHAN-1:0]   ch;
  logic [SEQ_WIDTH-1:0]  seq [NUM_CHAN];
  logic [15:0]           beat_cnt;
  logic                  load_en;
  logic                  s_hs;
  logic                  last_beat;
  logic [SEQ_WIDTH-1:0]  seq_cur;
  logic [7:0]            ch8;
  logic [DATA_WIDTH-1:0] hdr;

  // The output register is the only storage stage; it may load whenever empty or draining.
  assign load_en       = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = (state == BODY) & load_en;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  // A beat closes its output packet on the input tlast or when the segment is full.
  assign last_beat     = s_axis_tlast | (beat_cnt == LAST_IDX);

  // Header channel field is the low byte of tuser, zero-padded for narrow tuser.
  generate
    if (NUM_CHAN >= 8) begin : g_ch_wide
      assign ch8 = s_axis_tuser[7:0];
    end else begin : g_ch_narrow
      assign ch8 = {{(8 - NUM_CHAN){1'b0}}, s_axis_tuser};
    end
  endgenerate

  // Select the sequence number of the channel presented on tuser.
  always_comb begin
    seq_cur = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (s_axis_tuser == NUM_CHAN'(i)) seq_cur = seq[i];
    end
  end

  // Assemble the header word: marker, channel, sequence number.
  always_comb begin
    hdr        = '0;
    hdr[15:0]  = 16'(seq_cur);
    hdr[23:16] = ch8;
    hdr[31:24] = 8'hA5;
  end

  // Framing FSM with the registered output stage, sequence counters and sticky error.
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state         <= IDLE;
      ch            <= '0;
      beat_cnt      <= '0;
      chan_err      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      for (int i = 0; i < NUM_CHAN; i++) seq[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_tvalid && load_en) begin
            m_axis_tdata  <= hdr;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            ch            <= s_axis_tuser;
            for (int i = 0; i < NUM_CHAN; i++) begin
              if (s_axis_tuser == NUM_CHAN'(i)) seq[i] <= seq[i] + 1'b1;
            end
            state <= BODY;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
          end
        end
        BODY: begin
          if (s_hs) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_beat;
            if (s_axis_tuser != ch) chan_err <= 1'b1;
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_chan_packetizer.sv
// tb/tb_axis_chan_packetizer.sv - randomized self-checking bench for axis_chan_packetizer
module tb_axis_chan_packetizer;

  localparam int NC = 6;
  localparam int DW = 64;
  localparam int MB = 4;
  localparam int SW = 2;

  logic          clk;
  logic          rstn;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic [NC-1:0] s_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          chan_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_drive_cyc = 0;
  int mseq [NC];

  logic [DW:0] got[$];
  logic [DW:0] exp_q[$];
  int          got_cyc[$];

  axis_chan_packetizer #(
    .NUM_CHAN(NC), .DATA_WIDTH(DW), .MAX_BEATS(MB), .SEQ_WIDTH(SW)
  ) dut (
    .axis_clk(clk),
    .axis_rstn(rstn),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast),
    .chan_err(chan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output handshakes are captured half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      got.push_back({m_tlast, m_tdata});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model + driver: segment the packet into MB-beat chunks, each behind a header.
  task automatic send_packet(input int ch, input int n, input int bad);
    logic [DW-1:0] d;
    logic [DW:0]   h;
    int            t;
    for (int k = 0; k < n; k++) begin
      d = {$urandom, $urandom};
      if (k % MB == 0) begin
        h = '0;
        h[31:0] = {8'hA5, 8'(ch), 16'(mseq[ch])};
        exp_q.push_back(h);
        mseq[ch] = (mseq[ch] + 1) % (1 << SW);
      end
      exp_q.push_back({((k == n - 1) || (k % MB == MB - 1)), d});
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = (k == n - 1);
      s_tuser  = (k == bad) ? NC'((ch + 1) % NC) : NC'(ch);
      if (k == 0) first_drive_cyc = cyc;
      t = 0;
      @(negedge clk);
      while (!s_tready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!s_tready) begin
        checks++;
        errors++;
        $display("FAIL input_handshake_timeout ch=%0d beat=%0d", ch, k);
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int t;
    t = 0;
    while (got.size() < exp_q.size() && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    ok = (got.size() == exp_q.size());
  endtask

  task automatic clear_queues();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = '0;
    m_tready = 1'b1;
    for (int i = 0; i < NC; i++) mseq[i] = 0;
    @(posedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b expected 0", m_tvalid); end
    checks++; if (m_tdata !== '0)    begin errors++; $display("FAIL reset_m_tdata got %h expected 0", m_tdata); end
    checks++; if (m_tlast !== 1'b0)  begin errors++; $display("FAIL reset_m_tlast got %b expected 0", m_tlast); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b expected 0", s_tready); end
    checks++; if (chan_err !== 1'b0) begin errors++; $display("FAIL reset_chan_err got %b expected 0", chan_err); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_single_packet();
    bit ok;
    logic [DW:0] e;
    int gaps;
    send_packet(2, 3, -1);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t1_beat%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    e = '0;
    e[31:0] = 32'hA502_0000;
    if (got.size() > 0) begin
      checks++; if (got[0] !== e) begin errors++; $display("FAIL t1_header got %h expected %h", got[0], e); end
      checks++; if (got_cyc[0] !== first_drive_cyc + 1) begin errors++; $display("FAIL t1_hdr_latency got %0d expected %0d", got_cyc[0] - first_drive_cyc, 1); end
    end
    gaps = 0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i - 1] + 1) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("FAIL t1_gaps got %0d expected 0", gaps); end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int gaps;
    send_packet(2, 2, -1);
    send_packet(2, 2, -1);
    send_packet(0, 2, -1);
    drain(ok);
    checks++; if (!ok || got.size() != 9) begin errors++; $display("FAIL t2_count got %0d expected 9", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t2_beat%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    gaps = 0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i - 1] + 1) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("FAIL t2_gaps got %0d expected 0", gaps); end
    clear_queues();
  endtask

  task automatic test_split();
    bit ok;
    send_packet(5, 10, -1);
    drain(ok);
    checks++; if (!ok || got.size() != 13) begin errors++; $display("FAIL t3_count got %0d expected 13", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t3_beat%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    if (got.size() == 13) begin
      checks++; if (got[5][23:0] !== 24'h05_0001) begin errors++; $display("FAIL t3_hdr2 got %h expected 050001", got[5][23:0]); end
      checks++; if (got[10][23:0] !== 24'h05_0002) begin errors++; $display("FAIL t3_hdr3 got %h expected 050002", got[10][23:0]); end
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit done;
    logic pv, pr;
    logic [DW:0] pw;
    done = 1'b0;
    pv = 1'b0; pr = 1'b1; pw = '0;
    ok = 1'b0;
    fork
      begin
        send_packet(2, 6, -1);
        drain(ok);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (!done) m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (pv && !pr) begin
            checks++;
            if (!m_tvalid || {m_tlast, m_tdata} !== pw) begin
              errors++; $display("FAIL t4_stall_hold got %b/%h expected 1/%h", m_tvalid, {m_tlast, m_tdata}, pw);
            end
          end
          if (m_tvalid && !m_tready) begin
            checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL t4_stall_s_tready got %b expected 0", s_tready); end
          end
          pv = m_tvalid; pr = m_tready; pw = {m_tlast, m_tdata};
        end
      end
    join
    checks++; if (!ok) begin errors++; $display("FAIL t4_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t4_beat%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    clear_queues();
  endtask

  task automatic test_seq_wrap();
    bit ok;
    for (int p = 0; p < 5; p++) send_packet(1, 1, -1);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t5_beat%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    for (int p = 0; p < 5 && 2 * p < got.size(); p++) begin
      checks++; if (got[2 * p][15:0] !== 16'(p % 4)) begin errors++; $display("FAIL t5_seq%0d got %0d expected %0d", p, got[2 * p][15:0], p % 4); end
    end
    checks++; if (chan_err !== 1'b0) begin errors++; $display("FAIL t5_chan_err got %b expected 0", chan_err); end
    clear_queues();
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int hs, t;
    s_tvalid = 1'b1; s_tuser = NC'(3); s_tlast = 1'b0; s_tdata = {$urandom, $urandom} | 64'h1;
    hs = 0; t = 0;
    while (hs < 2 && t < 100) begin
      @(negedge clk);
      if (s_tready) begin
        hs++;
        @(posedge clk);
        #1;
        s_tdata = {$urandom, $urandom} | 64'h1;
      end else begin
        t++;
      end
    end
    checks++; if (hs != 2) begin errors++; $display("FAIL t6_prefix_handshakes got %0d expected 2", hs); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL t6_async_m_tvalid got %b expected 0", m_tvalid); end
    checks++; if (m_tdata !== '0)    begin errors++; $display("FAIL t6_async_m_tdata got %h expected 0", m_tdata); end
    checks++; if (m_tlast !== 1'b0)  begin errors++; $display("FAIL t6_async_m_tlast got %b expected 0", m_tlast); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL t6_async_s_tready got %b expected 0", s_tready); end
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_queues();
    for (int i = 0; i < NC; i++) mseq[i] = 0;
    send_packet(3, 3, -1);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t6_beat%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    if (got.size() > 0) begin
      checks++; if (got[0][23:0] !== 24'h03_0000) begin errors++; $display("FAIL t6_header got %h expected 030000", got[0][23:0]); end
    end
    clear_queues();
  endtask

  task automatic test_chan_err();
    bit ok;
    checks++; if (chan_err !== 1'b0) begin errors++; $display("FAIL t7_pre_chan_err got %b expected 0", chan_err); end
    send_packet(4, 3, 1);
    drain(ok);
    checks++; if (chan_err !== 1'b1) begin errors++; $display("FAIL t7_chan_err_set got %b expected 1", chan_err); end
    send_packet(0, 2, -1);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t7_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL t7_beat%0d got %h expected %h", i, got[i], exp_q[i]); end
    end
    checks++; if (chan_err !== 1'b1) begin errors++; $display("FAIL t7_chan_err_sticky got %b expected 1", chan_err); end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_split();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid_packet();
    test_chan_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
